id_ex_ctrl_pipe: RTL and testbench

- Next-generation control unit for the five-stage RISC-V pipeline. Combines ID-stage decode (RV32I base subset) with load-use hazard detection.
- Owns the ID/EX control register. Drives stall and flush signals to PC and IF/ID.
- Sits between the IF/ID register and the EX stage. Replaces per-stage decode-only control.

---
 rtl/rv_ctrl_pkg.sv | 69 ++++++
 rtl/id_ex_ctrl_pipe_if.sv | 52 +++++
 rtl/rv_ctrl_decode.sv | 106 ++++++++++
 rtl/id_ex_ctrl_pipe.sv | 118 +++++++++++
 tb/tb_id_ex_ctrl_pipe.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32I ID-stage control unit.
//   - major opcode constants (instruction bits [6:2])
//   - ALU, MemtoReg, Jump and ImmSel encodings
//   - ctrl_t: the control bundle carried from ID into the ID/EX register
//   - alu_from_f3: funct3 (+ alternate bit) to ALU control mapping
package rv_ctrl_pkg;

  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_LUI    = 5'b01101;

  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b1100;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1110;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SRA  = 4'b1111;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;
  localparam logic [1:0] M2R_IMM = 2'b11;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_JAL  = 2'b01;
  localparam logic [1:0] JMP_JALR = 2'b10;

  localparam logic [2:0] IMM_U = 3'b000;
  localparam logic [2:0] IMM_I = 3'b001;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  typedef struct packed {
    logic       alu_src_b;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       mem_rw;
    logic       br_en;
    logic [2:0] br_cond;
    logic [1:0] jump;
    logic [3:0] alu_ctrl;
    logic       ill_instr;
  } ctrl_t;

  // alt selects sub/sra; the caller decides when the alternate bit is meaningful.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_ctrl_pipe_if.sv
// ID-side and EX-side signal bundle of the control unit.
//   master: the pipeline around the unit (drives instruction, valid, ready, redirect)
//   slave : id_ex_ctrl_pipe (drives decode flags, stall/flush, ID/EX contents, counters)
// Handshake: valid_id qualifies inst_id; an instruction is consumed on a rising
// edge where MIO_ready=1 and neither pc_stall nor ifid_flush applies to it.
// MIO_ready=0 is a global freeze: nothing is consumed and all state holds.
interface id_ex_ctrl_pipe_if #(
  parameter int RF_AW       = 5,
  parameter int STALL_CNT_W = 16
);
  logic [31:0]            inst_id;
  logic                   valid_id;
  logic                   MIO_ready;
  logic                   redirect_ex;
  logic [2:0]             imm_sel_id;
  logic                   rs1_used_id;
  logic                   rs2_used_id;
  logic                   pc_stall;
  logic                   ifid_stall;
  logic                   ifid_flush;
  logic                   ex_valid;
  logic                   ex_alu_src_b;
  logic                   ex_reg_write;
  logic                   ex_mem_rw;
  logic                   ex_ill_instr;
  logic [3:0]             ex_alu_ctrl;
  logic [1:0]             ex_mem_to_reg;
  logic [1:0]             ex_jump;
  logic                   ex_br_en;
  logic [2:0]             ex_br_cond;
  logic [RF_AW-1:0]       ex_rd;
  logic [RF_AW-1:0]       ex_rs1;
  logic [RF_AW-1:0]       ex_rs2;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic [STALL_CNT_W-1:0] flush_cnt;

  modport master (
    output inst_id, valid_id, MIO_ready, redirect_ex,
    input  imm_sel_id, rs1_used_id, rs2_used_id, pc_stall, ifid_stall, ifid_flush,
           ex_valid, ex_alu_src_b, ex_reg_write, ex_mem_rw, ex_ill_instr, ex_alu_ctrl,
           ex_mem_to_reg, ex_jump, ex_br_en, ex_br_cond, ex_rd, ex_rs1, ex_rs2,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  inst_id, valid_id, MIO_ready, redirect_ex,
    output imm_sel_id, rs1_used_id, rs2_used_id, pc_stall, ifid_stall, ifid_flush,
           ex_valid, ex_alu_src_b, ex_reg_write, ex_mem_rw, ex_ill_instr, ex_alu_ctrl,
           ex_mem_to_reg, ex_jump, ex_br_en, ex_br_cond, ex_rd, ex_rs1, ex_rs2,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/rv_ctrl_decode.sv
// Purely combinational RV32I-subset decoder.
//   funct7, funct3, opcode : instruction fields from IF/ID
//   valid                  : IF/ID holds a real instruction; all outputs are 0 otherwise
//   ctrl                   : control bundle; an illegal instruction yields only ill_instr=1
//   imm_sel, rs1_used, rs2_used : immediate selector and source-register use flags
module rv_ctrl_decode import rv_ctrl_pkg::*; #(
  parameter int BRANCH_FULL = 1
) (
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  input  logic [6:0] opcode,
  input  logic       valid,
  output ctrl_t      ctrl,
  output logic [2:0] imm_sel,
  output logic       rs1_used,
  output logic       rs2_used
);

  logic ill;

  always_comb begin
    ctrl     = '0;
    imm_sel  = IMM_U;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    ill      = 1'b0;
    if (valid) begin
      ctrl.alu_ctrl = ALU_ADD;
      // Low bits other than 11 are compressed or reserved encodings.
      if (opcode[1:0] != 2'b11) begin
        ill = 1'b1;
      end else begin
        case (opcode[6:2])
          OP_R: begin
            rs1_used       = 1'b1;
            rs2_used       = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_ctrl  = alu_from_f3(funct3, funct7[5]);
            if (!(funct7 == 7'b0000000 ||
                  (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
              ill = 1'b1;
          end
          OP_LOAD: begin
            rs1_used        = 1'b1;
            imm_sel         = IMM_I;
            ctrl.alu_src_b  = 1'b1;
            ctrl.mem_to_reg = M2R_MEM;
            ctrl.reg_write  = 1'b1;
          end
          OP_IMM: begin
            rs1_used       = 1'b1;
            imm_sel        = IMM_I;
            ctrl.alu_src_b = 1'b1;
            ctrl.reg_write = 1'b1;
            // Only the shift-right group uses bit 30; addi never becomes sub.
            ctrl.alu_ctrl  = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
          end
          OP_STORE: begin
            rs1_used       = 1'b1;
            rs2_used       = 1'b1;
            imm_sel        = IMM_S;
            ctrl.alu_src_b = 1'b1;
            ctrl.mem_rw    = 1'b1;
          end
          OP_BRANCH: begin
            rs1_used      = 1'b1;
            rs2_used      = 1'b1;
            imm_sel       = IMM_B;
            ctrl.br_en    = 1'b1;
            ctrl.br_cond  = funct3;
            ctrl.alu_ctrl = ALU_SUB;
            if (BRANCH_FULL != 0) ill = (funct3[2:1] == 2'b01);
            else                  ill = (funct3[2:1] != 2'b00);
          end
          OP_JALR: begin
            rs1_used        = 1'b1;
            imm_sel         = IMM_I;
            ctrl.alu_src_b  = 1'b1;
            ctrl.mem_to_reg = M2R_PC4;
            ctrl.reg_write  = 1'b1;
            ctrl.jump       = JMP_JALR;
          end
          OP_JAL: begin
            imm_sel         = IMM_J;
            ctrl.mem_to_reg = M2R_PC4;
            ctrl.reg_write  = 1'b1;
            ctrl.jump       = JMP_JAL;
          end
          OP_LUI: begin
            imm_sel         = IMM_U;
            ctrl.alu_src_b  = 1'b1;
            ctrl.mem_to_reg = M2R_IMM;
            ctrl.reg_write  = 1'b1;
          end
          default: ill = 1'b1;
        endcase
      end
      // An illegal instruction must not write anything downstream.
      if (ill) begin
        ctrl           = '0;
        ctrl.ill_instr = 1'b1;
      end
    end
  end

endmodule

// File: rtl/id_ex_ctrl_pipe.sv
// ID-stage control unit: decode, load-use hazard detection, ID/EX control
// register and saturating stall/flush statistics.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : id_ex_ctrl_pipe_if slave (instruction in, decode flags,
//              pc_stall/ifid_stall/ifid_flush, registered ex_* bundle, counters)
// Edge priority: rst > freeze (MIO_ready=0) > redirect_ex > load-use hazard > load.
module id_ex_ctrl_pipe import rv_ctrl_pkg::*; #(
  parameter int RF_AW       = 5,
  parameter int BRANCH_FULL = 1,
  parameter int LOAD_USE_EN = 1,
  parameter int STALL_CNT_W = 16
) (
  input logic clk,
  input logic rst,
  id_ex_ctrl_pipe_if.slave bus
);

  ctrl_t            dec_ctrl;
  logic [2:0]       dec_imm_sel;
  logic             dec_rs1_used;
  logic             dec_rs2_used;
  logic [RF_AW-1:0] id_rd, id_rs1, id_rs2;

  ctrl_t                  ex_ctrl;
  logic                   ex_valid;
  logic [RF_AW-1:0]       ex_rd, ex_rs1, ex_rs2;
  logic [STALL_CNT_W-1:0] stall_cnt, flush_cnt;
  logic                   hazard;
  logic                   stall;
  logic                   flush;

  rv_ctrl_decode #(.BRANCH_FULL(BRANCH_FULL)) u_decode (
    .funct7   (bus.inst_id[31:25]),
    .funct3   (bus.inst_id[14:12]),
    .opcode   (bus.inst_id[6:0]),
    .valid    (bus.valid_id),
    .ctrl     (dec_ctrl),
    .imm_sel  (dec_imm_sel),
    .rs1_used (dec_rs1_used),
    .rs2_used (dec_rs2_used)
  );

  assign id_rd  = bus.valid_id ? bus.inst_id[7  +: RF_AW] : '0;
  assign id_rs1 = bus.valid_id ? bus.inst_id[15 +: RF_AW] : '0;
  assign id_rs2 = bus.valid_id ? bus.inst_id[20 +: RF_AW] : '0;

  // A load in EX whose destination is read by the instruction in ID. Only the
  // flagged sources count, so immediate bits sitting in the rs2 field are ignored.
  assign hazard = (LOAD_USE_EN != 0) && bus.valid_id &&
                  ex_valid && ex_ctrl.reg_write && (ex_ctrl.mem_to_reg == M2R_MEM) &&
                  (ex_rd != '0) &&
                  ((dec_rs1_used && (id_rs1 == ex_rd)) ||
                   (dec_rs2_used && (id_rs2 == ex_rd)));

  always_comb begin
    stall = 1'b0;
    flush = 1'b0;
    if (!rst) begin
      if (!bus.MIO_ready)      stall = 1'b1;
      else if (bus.redirect_ex) flush = 1'b1;
      else if (hazard)          stall = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl   <= '0;
      ex_valid  <= 1'b0;
      ex_rd     <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (bus.MIO_ready) begin
      if (bus.redirect_ex || hazard) begin
        ex_ctrl  <= '0;
        ex_valid <= 1'b0;
        ex_rd    <= '0;
        ex_rs1   <= '0;
        ex_rs2   <= '0;
        if (bus.redirect_ex) begin
          if (flush_cnt != '1) flush_cnt <= flush_cnt + STALL_CNT_W'(1);
        end else begin
          if (stall_cnt != '1) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
      end else begin
        ex_ctrl  <= dec_ctrl;
        ex_valid <= bus.valid_id;
        ex_rd    <= id_rd;
        ex_rs1   <= id_rs1;
        ex_rs2   <= id_rs2;
      end
    end
  end

  assign bus.imm_sel_id    = dec_imm_sel;
  assign bus.rs1_used_id   = dec_rs1_used;
  assign bus.rs2_used_id   = dec_rs2_used;
  assign bus.pc_stall      = stall;
  assign bus.ifid_stall    = stall;
  assign bus.ifid_flush    = flush;
  assign bus.ex_valid      = ex_valid;
  assign bus.ex_alu_src_b  = ex_ctrl.alu_src_b;
  assign bus.ex_reg_write  = ex_ctrl.reg_write;
  assign bus.ex_mem_rw     = ex_ctrl.mem_rw;
  assign bus.ex_ill_instr  = ex_ctrl.ill_instr;
  assign bus.ex_alu_ctrl   = ex_ctrl.alu_ctrl;
  assign bus.ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign bus.ex_jump       = ex_ctrl.jump;
  assign bus.ex_br_en      = ex_ctrl.br_en;
  assign bus.ex_br_cond    = ex_ctrl.br_cond;
  assign bus.ex_rd         = ex_rd;
  assign bus.ex_rs1        = ex_rs1;
  assign bus.ex_rs2        = ex_rs2;
  assign bus.stall_cnt     = stall_cnt;
  assign bus.flush_cnt     = flush_cnt;

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Bench for id_ex_ctrl_pipe. dut0 uses default parameters; dut1 (BRANCH_FULL=0,
// STALL_CNT_W=2) receives identical stimulus and is checked where it differs.
// EX word layout: {valid, ill, alu[3:0], m2r[1:0], jump[1:0], rw, mrw, src_b,
//                  br_en, br_cond[2:0], rd[4:0], rs1[4:0], rs2[4:0]}
module tb_id_ex_ctrl_pipe;

  localparam logic [6:0] R = 7'h33, LD = 7'h03, OPI = 7'h13, ST = 7'h23;
  localparam logic [6:0] BR = 7'h63, JALR = 7'h67, JAL = 7'h6F, LUI = 7'h37;
  localparam logic [3:0] A_ADD = 4'b0010, A_SUB = 4'b0110, A_SRA = 4'b1111;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [31:0] exp_q[$];

  id_ex_ctrl_pipe_if #(.RF_AW(5), .STALL_CNT_W(16)) if0 ();
  id_ex_ctrl_pipe_if #(.RF_AW(5), .STALL_CNT_W(2))  if1 ();

  id_ex_ctrl_pipe #(.RF_AW(5), .BRANCH_FULL(1), .LOAD_USE_EN(1), .STALL_CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .bus(if0));
  id_ex_ctrl_pipe #(.RF_AW(5), .BRANCH_FULL(0), .LOAD_USE_EN(1), .STALL_CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .bus(if1));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish obs=running exp=done");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic v, input logic ill, input logic [3:0] alu,
                                     input logic [1:0] m2r, input logic [1:0] j,
                                     input logic rw, input logic mrw, input logic sb,
                                     input logic be, input logic [2:0] bc,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
    return {v, ill, alu, m2r, j, rw, mrw, sb, be, bc, rd, rs1, rs2};
  endfunction

  function automatic logic [31:0] pack0();
    return {if0.ex_valid, if0.ex_ill_instr, if0.ex_alu_ctrl, if0.ex_mem_to_reg, if0.ex_jump,
            if0.ex_reg_write, if0.ex_mem_rw, if0.ex_alu_src_b, if0.ex_br_en, if0.ex_br_cond,
            if0.ex_rd, if0.ex_rs1, if0.ex_rs2};
  endfunction

  function automatic logic [31:0] pack1();
    return {if1.ex_valid, if1.ex_ill_instr, if1.ex_alu_ctrl, if1.ex_mem_to_reg, if1.ex_jump,
            if1.ex_reg_write, if1.ex_mem_rw, if1.ex_alu_src_b, if1.ex_br_en, if1.ex_br_cond,
            if1.ex_rd, if1.ex_rs1, if1.ex_rs2};
  endfunction

  function automatic logic [31:0] rt(input logic [6:0] f7, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [2:0] f3,
                                     input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, R};
  endfunction

  function automatic logic [31:0] it(input logic [11:0] imm, input logic [4:0] rs1,
                                     input logic [2:0] f3, input logic [4:0] rd,
                                     input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] sbt(input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [6:0] op);
    return {7'b0, rs2, rs1, f3, 5'b0, op};
  endfunction

  function automatic logic [3:0] r_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? 4'b0110 : 4'b0010;
      3'b001:  return 4'b1110;
      3'b010:  return 4'b0111;
      3'b011:  return 4'b1001;
      3'b100:  return 4'b1100;
      3'b101:  return alt ? 4'b1111 : 4'b1101;
      3'b110:  return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // driver: one ID cycle; checks combinational outputs mid-cycle, then the
  // ID/EX contents one edge later against the queued expectation
  task automatic step(input string tag, input logic [31:0] inst, input logic vld,
                      input logic mio, input logic redir, input logic r,
                      input logic [31:0] exp_ex, input logic exp_stall,
                      input logic exp_flush, input logic [4:0] exp_id);
    logic [31:0] e;
    @(negedge clk);
    rst = r;
    if0.inst_id = inst;  if0.valid_id = vld;  if0.MIO_ready = mio;  if0.redirect_ex = redir;
    if1.inst_id = inst;  if1.valid_id = vld;  if1.MIO_ready = mio;  if1.redirect_ex = redir;
    #1;
    check({tag, ":stall"}, {30'b0, if0.pc_stall, if0.ifid_stall}, {30'b0, exp_stall, exp_stall});
    check({tag, ":flush"}, {31'b0, if0.ifid_flush}, {31'b0, exp_flush});
    check({tag, ":id"}, {27'b0, if0.imm_sel_id, if0.rs1_used_id, if0.rs2_used_id}, {27'b0, exp_id});
    exp_q.push_back(exp_ex);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ":ex"}, pack0(), e);
  endtask

  task automatic idle(input string tag);
    step(tag, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'b0);
  endtask

  logic [31:0] lw5, add_dep, w_lw5, w_add_dep;
  logic [2:0]  f3r;
  logic        altr;
  logic [4:0]  rdr, rs1r, rs2r;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    if0.inst_id = '0; if0.valid_id = 1'b0; if0.MIO_ready = 1'b0; if0.redirect_ex = 1'b0;
    if1.inst_id = '0; if1.valid_id = 1'b0; if1.MIO_ready = 1'b0; if1.redirect_ex = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // reset state; stall outputs stay low under rst even with MIO_ready=0
    check("rst_ex", pack0(), 32'h0);
    check("rst_cnt", {if0.stall_cnt, if0.flush_cnt}, 32'h0);
    check("rst_stall", {31'b0, if0.pc_stall}, 32'h0);

    lw5       = it(12'd0, 5'd1, 3'b010, 5'd5, LD);
    add_dep   = rt(7'b0, 5'd2, 5'd5, 3'b000, 5'd6);
    w_lw5     = mk(1, 0, A_ADD, 2'b01, 2'b00, 1, 0, 1, 0, 3'b000, 5'd5, 5'd1, 5'd0);
    w_add_dep = mk(1, 0, A_ADD, 2'b00, 2'b00, 1, 0, 0, 0, 3'b000, 5'd6, 5'd5, 5'd2);

    // decode
    step("add", rt(7'b0, 5'd2, 5'd1, 3'b000, 5'd3), 1, 1, 0, 0,
         mk(1, 0, A_ADD, 2'b00, 2'b00, 1, 0, 0, 0, 3'b000, 5'd3, 5'd1, 5'd2), 0, 0, 5'b000_11);
    idle("i0");
    step("lw", it(12'd8, 5'd1, 3'b010, 5'd4, LD), 1, 1, 0, 0,
         mk(1, 0, A_ADD, 2'b01, 2'b00, 1, 0, 1, 0, 3'b000, 5'd4, 5'd1, 5'd8), 0, 0, 5'b001_10);
    idle("i1");
    step("sw", sbt(5'd2, 5'd1, 3'b010, ST), 1, 1, 0, 0,
         mk(1, 0, A_ADD, 2'b00, 2'b00, 0, 1, 1, 0, 3'b000, 5'd0, 5'd1, 5'd2), 0, 0, 5'b010_11);
    idle("i2");
    step("beq", sbt(5'd2, 5'd1, 3'b000, BR), 1, 1, 0, 0,
         mk(1, 0, A_SUB, 2'b00, 2'b00, 0, 0, 0, 1, 3'b000, 5'd0, 5'd1, 5'd2), 0, 0, 5'b011_11);
    idle("i3");
    step("jal", {20'b0, 5'd1, JAL}, 1, 1, 0, 0,
         mk(1, 0, A_ADD, 2'b10, 2'b01, 1, 0, 0, 0, 3'b000, 5'd1, 5'd0, 5'd0), 0, 0, 5'b100_00);
    idle("i4");
    step("lui", {20'b0, 5'd5, LUI}, 1, 1, 0, 0,
         mk(1, 0, A_ADD, 2'b11, 2'b00, 1, 0, 1, 0, 3'b000, 5'd5, 5'd0, 5'd0), 0, 0, 5'b000_00);
    idle("i5");
    step("jalr", it(12'd0, 5'd2, 3'b000, 5'd1, JALR), 1, 1, 0, 0,
         mk(1, 0, A_ADD, 2'b10, 2'b10, 1, 0, 1, 0, 3'b000, 5'd1, 5'd2, 5'd0), 0, 0, 5'b001_10);
    step("srai", it({7'b0100000, 5'd3}, 5'd1, 3'b101, 5'd7, OPI), 1, 1, 0, 0,
         mk(1, 0, A_SRA, 2'b00, 2'b00, 1, 0, 1, 0, 3'b000, 5'd7, 5'd1, 5'd3), 0, 0, 5'b001_10);
    step("sub", rt(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd8), 1, 1, 0, 0,
         mk(1, 0, A_SUB, 2'b00, 2'b00, 1, 0, 0, 0, 3'b000, 5'd8, 5'd1, 5'd2), 0, 0, 5'b000_11);

    // illegal encodings
    step("ill_r", rt(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd8), 1, 1, 0, 0,
         mk(1, 1, 4'b0, 2'b00, 2'b00, 0, 0, 0, 0, 3'b000, 5'd8, 5'd1, 5'd2), 0, 0, 5'b000_11);
    step("ill_op", 32'h0000_007F, 1, 1, 0, 0,
         mk(1, 1, 4'b0, 2'b00, 2'b00, 0, 0, 0, 0, 3'b000, 5'd0, 5'd0, 5'd0), 0, 0, 5'b000_00);
    step("blt", sbt(5'd2, 5'd1, 3'b100, BR), 1, 1, 0, 0,
         mk(1, 0, A_SUB, 2'b00, 2'b00, 0, 0, 0, 1, 3'b100, 5'd0, 5'd1, 5'd2), 0, 0, 5'b011_11);
    check("blt_bf0", pack1(), mk(1, 1, 4'b0, 2'b00, 2'b00, 0, 0, 0, 0, 3'b000, 5'd0, 5'd1, 5'd2));
    step("br010", sbt(5'd2, 5'd1, 3'b010, BR), 1, 1, 0, 0,
         mk(1, 1, 4'b0, 2'b00, 2'b00, 0, 0, 0, 0, 3'b000, 5'd0, 5'd1, 5'd2), 0, 0, 5'b011_11);
    idle("i6");

    // load-use on rs1: one stall cycle, then the add enters EX
    step("lu_lw", lw5, 1, 1, 0, 0, w_lw5, 0, 0, 5'b001_10);
    step("lu_stall", add_dep, 1, 1, 0, 0, 32'h0, 1, 0, 5'b000_11);
    step("lu_add", add_dep, 1, 1, 0, 0, w_add_dep, 0, 0, 5'b000_11);
    check("lu_cnt", 32'(if0.stall_cnt), 32'd1);
    idle("i7");
    // independent add
    step("nd_lw", lw5, 1, 1, 0, 0, w_lw5, 0, 0, 5'b001_10);
    step("nd_add", rt(7'b0, 5'd2, 5'd7, 3'b000, 5'd6), 1, 1, 0, 0,
         mk(1, 0, A_ADD, 2'b00, 2'b00, 1, 0, 0, 0, 3'b000, 5'd6, 5'd7, 5'd2), 0, 0, 5'b000_11);
    // load into x0 never stalls
    step("x0_lw", it(12'd0, 5'd1, 3'b010, 5'd0, LD), 1, 1, 0, 0,
         mk(1, 0, A_ADD, 2'b01, 2'b00, 1, 0, 1, 0, 3'b000, 5'd0, 5'd1, 5'd0), 0, 0, 5'b001_10);
    step("x0_add", rt(7'b0, 5'd2, 5'd0, 3'b000, 5'd6), 1, 1, 0, 0,
         mk(1, 0, A_ADD, 2'b00, 2'b00, 1, 0, 0, 0, 3'b000, 5'd6, 5'd0, 5'd2), 0, 0, 5'b000_11);
    // immediate bits in the rs2 field match ex_rd but rs2 is unused
    step("im_lw", lw5, 1, 1, 0, 0, w_lw5, 0, 0, 5'b001_10);
    step("im_addi", it(12'd5, 5'd1, 3'b000, 5'd6, OPI), 1, 1, 0, 0,
         mk(1, 0, A_ADD, 2'b00, 2'b00, 1, 0, 1, 0, 3'b000, 5'd6, 5'd1, 5'd5), 0, 0, 5'b001_10);
    // load-use on rs2 of a store
    step("s2_lw", lw5, 1, 1, 0, 0, w_lw5, 0, 0, 5'b001_10);
    step("s2_stall", sbt(5'd5, 5'd1, 3'b010, ST), 1, 1, 0, 0, 32'h0, 1, 0, 5'b010_11);
    step("s2_sw", sbt(5'd5, 5'd1, 3'b010, ST), 1, 1, 0, 0,
         mk(1, 0, A_ADD, 2'b00, 2'b00, 0, 1, 1, 0, 3'b000, 5'd0, 5'd1, 5'd5), 0, 0, 5'b010_11);
    check("s2_cnt", 32'(if0.stall_cnt), 32'd2);
    idle("i8");

    // redirect beats a coincident hazard
    step("fl_lw", lw5, 1, 1, 0, 0, w_lw5, 0, 0, 5'b001_10);
    step("fl_redir", add_dep, 1, 1, 1, 0, 32'h0, 0, 1, 5'b000_11);
    check("fl_cnt", {if0.stall_cnt, if0.flush_cnt}, {16'd2, 16'd1});
    idle("i9");

    // freeze during a hazard: everything holds, even with a redirect present
    step("fz_lw", lw5, 1, 1, 0, 0, w_lw5, 0, 0, 5'b001_10);
    step("fz_0", add_dep, 1, 0, 0, 0, w_lw5, 1, 0, 5'b000_11);
    step("fz_1", add_dep, 1, 0, 1, 0, w_lw5, 1, 0, 5'b000_11);
    step("fz_2", add_dep, 1, 0, 0, 0, w_lw5, 1, 0, 5'b000_11);
    check("fz_cnt", {if0.stall_cnt, if0.flush_cnt}, {16'd2, 16'd1});
    step("fz_rel", add_dep, 1, 1, 0, 0, 32'h0, 1, 0, 5'b000_11);
    step("fz_add", add_dep, 1, 1, 0, 0, w_add_dep, 0, 0, 5'b000_11);
    check("fz_cnt2", 32'(if0.stall_cnt), 32'd3);
    idle("i10");

    // more stalls: dut1's 2-bit counter saturates
    for (int k = 0; k < 2; k++) begin
      step("sat_lw", lw5, 1, 1, 0, 0, w_lw5, 0, 0, 5'b001_10);
      step("sat_stall", add_dep, 1, 1, 0, 0, 32'h0, 1, 0, 5'b000_11);
      step("sat_add", add_dep, 1, 1, 0, 0, w_add_dep, 0, 0, 5'b000_11);
    end
    check("sat_cnt0", 32'(if0.stall_cnt), 32'd5);
    check("sat_cnt1", {28'b0, if1.stall_cnt, if1.flush_cnt}, {28'b0, 2'd3, 2'd1});

    // random legal R-type traffic
    for (int k = 0; k < 8; k++) begin
      f3r  = 3'($urandom_range(0, 7));
      altr = (f3r == 3'b000 || f3r == 3'b101) ? 1'($urandom_range(0, 1)) : 1'b0;
      rdr  = 5'($urandom_range(1, 31));
      rs1r = 5'($urandom_range(0, 31));
      rs2r = 5'($urandom_range(0, 31));
      step("rnd", rt({1'b0, altr, 5'b0}, rs2r, rs1r, f3r, rdr), 1, 1, 0, 0,
           mk(1, 0, r_alu(f3r, altr), 2'b00, 2'b00, 1, 0, 0, 0, 3'b000, rdr, rs1r, rs2r),
           0, 0, 5'b000_11);
    end
    idle("i11");

    // reset mid-stall clears everything at the next edge
    step("rs_lw", lw5, 1, 1, 0, 0, w_lw5, 0, 0, 5'b001_10);
    step("rs_rst", add_dep, 1, 1, 0, 1, 32'h0, 0, 0, 5'b000_11);
    check("rs_cnt0", {if0.stall_cnt, if0.flush_cnt}, 32'h0);
    check("rs_cnt1", {28'b0, if1.stall_cnt, if1.flush_cnt}, 32'h0);
    check("rs_ex1", pack1(), 32'h0);
    step("rs_add", add_dep, 1, 1, 0, 0, w_add_dep, 0, 0, 5'b000_11);
    idle("i12");

    check("q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
